pipe_mem_ctrl: RTL and testbench
================================

# pipe_mem_ctrl

Pipeline sequencing controller for the MEM stage of the five-stage RISC-V core. It issues data-memory accesses from the EX/MEM register and holds the whole pipeline while a variable-latency memory responds. It also generates the taken-branch flush and load-use bubble controls for the PC, IF/ID, ID/EX and EX/MEM registers. It sits beside EXMEM and drives its `exflush` and a new hold input, plus the equivalent controls on the other stage registers.

## Interface
- `TIMEOUT`, default 64: maximum WAIT cycles before the access is declared failed; legal range 2..65535.
- `ADDR_WIDTH`, default `PC_WIDTH`: data address width.
- `DATA_WIDTH`, default `REG_DATA_WIDTH`: data width.

Ports:
- `clk`  input  1  core clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `memread_mem`  input  1  load in MEM stage.
- `memwrite_mem`  input  1  store in MEM stage.
- `alu_result_mem`  input  ADDR_WIDTH  access address.
- `read_data2_forwarded_mem`  input  DATA_WIDTH  store data.
- `branch_taken_mem`  input  1  resolved taken branch/jump in MEM.
- `loaduse_hazard`  input  1  load-use hazard detected in ID.
- `dmem_ack`  input  1  memory completes the current access this cycle.
- `dmem_rdata`  input  DATA_WIDTH  load data; valid when `dmem_ack` is 1.
- `dmem_req`  output  1  access request.
- `dmem_we`  output  1  1 = write.
- `dmem_addr`  output  ADDR_WIDTH  request address.
- `dmem_wdata`  output  DATA_WIDTH  request write data.
- `load_data_mem`  output  DATA_WIDTH  load data toward MEM/WB.
- `stall_pc`, `stall_ifid`, `stall_idex`, `stall_exmem`  output  1 each  hold the corresponding register.
- `memwb_bubble`  output  1  MEM/WB loads a NOP.
- `flush_ifid`, `flush_idex`, `exflush`  output  1 each  flush the corresponding register.
- `bus_error`  output  1  sticky timeout flag.
- `stall_cycles`  output  32  count of memory-stall cycles.

## Operation
Let `acc = memread_mem | memwrite_mem`.

States:
- IDLE (reset state).
- WAIT.
- ERR.

Transitions:
- IDLE: if `acc & ~dmem_ack`, go to WAIT. Otherwise stay in IDLE; a zero-wait access completes in the same cycle.
- WAIT: on `dmem_ack`, go to IDLE. If `dmem_ack` is still 0 when the timeout counter equals `TIMEOUT-1`, go to ERR.
- ERR: terminal until reset.

Memory interface (all combinational):
- `dmem_req = (IDLE & acc) | WAIT`.
- `dmem_we = memwrite_mem & dmem_req`.
- `dmem_addr` and `dmem_wdata` pass through from the inputs; they stay stable while stalled because EX/MEM is held.
- `load_data_mem = dmem_rdata`.

Memory stall:
- `mstall = (IDLE & acc & ~dmem_ack) | (WAIT & ~dmem_ack) | ERR`.
- When `mstall` is 1: `stall_pc`, `stall_ifid`, `stall_idex` and `stall_exmem` are 1, and `memwb_bubble` is 1.

Priority (combinational), with `mstall` highest:
1. `mstall`: as above. No flush outputs are asserted. A coincident branch or load-use input is ignored this cycle; it is re-evaluated once the stall ends because the upstream registers are held.
2. Else `branch_taken_mem`: `flush_ifid`, `flush_idex` and `exflush` are 1; no stalls.
3. Else `loaduse_hazard`: `stall_pc` and `stall_ifid` are 1, and `flush_idex` is 1 (bubble).
4. Else all controls are 0.

Timeout counter:
- 16-bit.
- Cleared on entry to WAIT and in IDLE.
- Increments each WAIT cycle without `dmem_ack`.

`bus_error`:
- Set on entry to ERR.
- Cleared only by reset.
- In ERR, `dmem_req` is 0 and all stalls are held.

`stall_cycles`:
- Increments every cycle `mstall` is 1, including ERR.
- Saturates at 0xFFFFFFFF.

## Timing
Reset (`rst` = 0, asynchronous): state goes to IDLE, the timeout counter, `bus_error` and `stall_cycles` go to 0. Every combinational output then evaluates from IDLE with the current inputs; with no access and no hazard, all outputs are 0.

Latency and stall length:
- Access latency in MEM is 1 cycle plus N, where N is the number of cycles before `dmem_ack`.
- Stall length is exactly N cycles.
- With N = 0 there is no stall.

Handshake rules:
- `dmem_req` stays high from issue until the cycle of `dmem_ack`.
- Address, data and `we` are unchanged throughout the request.
- `dmem_ack` with `dmem_req` = 0 is ignored.
- The cycle after an ack, the pipeline has advanced. A new access in MEM is issued immediately from IDLE; back-to-back accesses have no idle gap.
- A taken branch and a memory access never coexist in MEM. If both are asserted, the stall still wins.

Reset mid-WAIT: the request drops immediately (asynchronously) and the counters clear.

## Test plan
- Zero-wait load: memread=1 with ack in the same cycle → `dmem_req`=1, all stalls 0, `load_data_mem`=`dmem_rdata`; `stall_cycles` stays 0.
- 3-wait store: memwrite=1, addr=0x100, wdata=0xDEADBEEF, ack in the 4th cycle → 3 cycles with all stalls and `memwb_bubble`=1; addr/wdata/we stable throughout; `stall_cycles`=3; state back to IDLE.
- Back-to-back loads with 2-wait then 0-wait → second request is issued on the cycle after the first ack; `stall_cycles`=2.
- Priority: `branch_taken_mem`=1 and `loaduse_hazard`=1 → only the flushes (ifid, idex, exflush)=1 and `stall_pc`=0. `loaduse_hazard` alone → `stall_pc`, `stall_ifid` and `flush_idex`=1.
- Timeout with TIMEOUT=4, load with no ack → ERR after 4 WAIT cycles, `bus_error`=1, `dmem_req`=0, stalls held; `rst`=0 clears everything.
- Asynchronous reset asserted mid-WAIT between clock edges → `dmem_req` and the stalls fall without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_mem_ctrl.sv
// MEM-stage sequencing controller: issues data-memory accesses, holds the pipeline
// during variable-latency responses, and resolves branch-flush / load-use controls.
module pipe_mem_ctrl #(
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  memread_mem,
   input  logic                  memwrite_mem,
   input  logic [ADDR_WIDTH-1:0] alu_result_mem,
   input  logic [DATA_WIDTH-1:0] read_data2_forwarded_mem,
   input  logic                  branch_taken_mem,
   input  logic                  loaduse_hazard,
   input  logic                  dmem_ack,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [DATA_WIDTH-1:0] load_data_mem,
   output logic                  stall_pc,
   output logic                  stall_ifid,
   output logic                  stall_idex,
   output logic                  stall_exmem,
   output logic                  memwb_bubble,
   output logic                  flush_ifid,
   output logic                  flush_idex,
   output logic                  exflush,
   output logic                  bus_error,
   output logic [31:0]           stall_cycles
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned SC_W  = 32;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ERR  = 2'd2;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [SC_W-1:0]  SC_MAX  = '1;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
   logic             bus_error_nxt;
   logic [SC_W-1:0]  stall_cycles_nxt;
   logic             acc;
   logic             mstall;

   assign acc           = memread_mem | memwrite_mem;
   assign dmem_addr     = alu_result_mem;
   assign dmem_wdata    = read_data2_forwarded_mem;
   assign load_data_mem = dmem_rdata;

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         to_cnt       <= '0;
         bus_error    <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state        <= state_nxt;
         to_cnt       <= to_cnt_nxt;
         bus_error    <= bus_error_nxt;
         stall_cycles <= stall_cycles_nxt;
      end
   end

   // Next-state, memory handshake and pipeline control decode
   always_comb begin
      state_nxt        = state;
      to_cnt_nxt       = to_cnt;
      bus_error_nxt    = bus_error;
      stall_cycles_nxt = stall_cycles;
      mstall           = 1'b0;
      dmem_req         = 1'b0;
      dmem_we          = 1'b0;
      stall_pc         = 1'b0;
      stall_ifid       = 1'b0;
      stall_idex       = 1'b0;
      stall_exmem      = 1'b0;
      memwb_bubble     = 1'b0;
      flush_ifid       = 1'b0;
      flush_idex       = 1'b0;
      exflush          = 1'b0;

      case (state)
         S_IDLE: begin
            to_cnt_nxt = '0;
            dmem_req   = acc;
            mstall     = acc & ~dmem_ack;
            if (acc && !dmem_ack) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            dmem_req = 1'b1;
            mstall   = ~dmem_ack;
            if (dmem_ack) begin
               state_nxt  = S_IDLE;
               to_cnt_nxt = '0;
            end else if (to_cnt == TO_LAST) begin
               state_nxt     = S_ERR;
               bus_error_nxt = 1'b1;
            end else begin
               to_cnt_nxt = to_cnt + CNT_W'(1);
            end
         end
         S_ERR: begin
            mstall = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      dmem_we = memwrite_mem & dmem_req;

      // Memory stall outranks branch flush, which outranks the load-use bubble
      if (mstall) begin
         stall_pc     = 1'b1;
         stall_ifid   = 1'b1;
         stall_idex   = 1'b1;
         stall_exmem  = 1'b1;
         memwb_bubble = 1'b1;
      end else if (branch_taken_mem) begin
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
         exflush    = 1'b1;
      end else if (loaduse_hazard) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
         flush_idex = 1'b1;
      end

      if (mstall && stall_cycles != SC_MAX) stall_cycles_nxt = stall_cycles + SC_W'(1);
   end

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Scoreboard bench for pipe_mem_ctrl: a transaction-level model queues per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_pipe_mem_ctrl;

   localparam int unsigned TO = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          memread_mem, memwrite_mem;
   logic [AW-1:0] alu_result_mem;
   logic [DW-1:0] read_data2_forwarded_mem;
   logic          branch_taken_mem, loaduse_hazard;
   logic          dmem_ack;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_req, dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata, load_data_mem;
   logic          stall_pc, stall_ifid, stall_idex, stall_exmem, memwb_bubble;
   logic          flush_ifid, flush_idex, exflush;
   logic          bus_error;
   logic [31:0]   stall_cycles;

   pipe_mem_ctrl #(.TIMEOUT(TO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .memread_mem(memread_mem), .memwrite_mem(memwrite_mem),
      .alu_result_mem(alu_result_mem), .read_data2_forwarded_mem(read_data2_forwarded_mem),
      .branch_taken_mem(branch_taken_mem), .loaduse_hazard(loaduse_hazard),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .load_data_mem(load_data_mem),
      .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
      .stall_exmem(stall_exmem), .memwb_bubble(memwb_bubble),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .exflush(exflush),
      .bus_error(bus_error), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem, memwb_bubble, flush_ifid, flush_idex, exflush}
   typedef struct {
      logic          req;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic [7:0]    ctl;
      logic          berr;
      logic [31:0]   scyc;
   } exp_t;

   exp_t   q[$];
   int     checks = 0;
   int     errors = 0;
   longint m_scnt = 0;

   function automatic logic [7:0] act_ctl();
      return {stall_pc, stall_ifid, stall_idex, stall_exmem, memwb_bubble,
              flush_ifid, flush_idex, exflush};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("dmem_req", 64'(dmem_req), 64'(e.req));
         chk("dmem_we", 64'(dmem_we), 64'(e.we));
         chk("dmem_addr", 64'(dmem_addr), 64'(e.addr));
         chk("dmem_wdata", 64'(dmem_wdata), 64'(e.wdata));
         chk("load_data", 64'(load_data_mem), 64'(e.rdata));
         chk("controls", 64'(act_ctl()), 64'(e.ctl));
         chk("bus_error", 64'(bus_error), 64'(e.berr));
         chk("stall_cycles", 64'(stall_cycles), 64'(e.scyc));
      end
   end

   task automatic set_in(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic ack, input logic br, input logic lu);
      memread_mem              = rd;
      memwrite_mem             = wr;
      alu_result_mem           = a;
      read_data2_forwarded_mem = d;
      dmem_ack                 = ack;
      branch_taken_mem         = br;
      loaduse_hazard           = lu;
      dmem_rdata               = $urandom;
   endtask

   // Reference: a stalled cycle holds everything; otherwise branch beats load-use
   task automatic expect_cycle(input logic req, input logic we, input logic stalled,
                               input logic br, input logic lu, input logic berr);
      exp_t e;
      e.req   = req;
      e.we    = we;
      e.addr  = alu_result_mem;
      e.wdata = read_data2_forwarded_mem;
      e.rdata = dmem_rdata;
      if (stalled)  e.ctl = 8'b1111_1000;
      else if (br)  e.ctl = 8'b0000_0111;
      else if (lu)  e.ctl = 8'b1100_0010;
      else          e.ctl = 8'b0000_0000;
      e.berr = berr;
      e.scyc = 32'(m_scnt);
      if (stalled && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      q.push_back(e);
   endtask

   task automatic idle_cycle(input logic br, input logic lu);
      @(posedge clk); #1;
      set_in(1'b0, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), br, lu);
      expect_cycle(1'b0, 1'b0, 1'b0, br, lu, 1'b0);
   endtask

   // Access acked after n wait cycles (n <= TO): n stalled cycles then the ack cycle
   task automatic do_access(input logic wr, input int n, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      for (int c = 0; c <= n; c++) begin
         logic ack, br, lu;
         @(posedge clk); #1;
         ack = (c == n);
         br  = ack ? 1'b0 : 1'($urandom_range(0, 1));
         lu  = 1'($urandom_range(0, 1));
         set_in(~wr, wr, a, d, ack, br, lu);
         expect_cycle(1'b1, wr, ~ack, br, lu, 1'b0);
      end
   endtask

   // Never-acked load: TO+1 requesting stall cycles, then a terminal error hold
   task automatic do_timeout(input logic [AW-1:0] a);
      for (int c = 0; c <= int'(TO) + 3; c++) begin
         logic br, lu, in_err;
         @(posedge clk); #1;
         br = 1'($urandom_range(0, 1));
         lu = 1'($urandom_range(0, 1));
         in_err = (c > int'(TO));
         set_in(1'b1, 1'b0, a, $urandom, 1'b0, br, lu);
         expect_cycle(~in_err, 1'b0, 1'b1, br, lu, in_err);
      end
   endtask

   task automatic async_reset_check(input string tag);
      @(negedge clk); #2;
      rst          = 1'b0;
      memread_mem  = 1'b0;
      memwrite_mem = 1'b0;
      dmem_ack     = 1'b0;
      branch_taken_mem = 1'b0;
      loaduse_hazard   = 1'b0;
      #1;
      chk({tag, "_req"}, 64'(dmem_req), 64'd0);
      chk({tag, "_ctl"}, 64'(act_ctl()), 64'd0);
      chk({tag, "_berr"}, 64'(bus_error), 64'd0);
      chk({tag, "_scyc"}, 64'(stall_cycles), 64'd0);
      m_scnt = 0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #3;
      chk("reset_req", 64'(dmem_req), 64'd0);
      chk("reset_ctl", 64'(act_ctl()), 64'd0);
      chk("reset_berr", 64'(bus_error), 64'd0);
      chk("reset_scyc", 64'(stall_cycles), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      do_access(1'b0, 0, $urandom, $urandom);
      do_access(1'b1, 3, 32'h0000_0100, 32'hDEAD_BEEF);
      idle_cycle(1'b0, 1'b0);
      do_access(1'b0, 2, $urandom, $urandom);
      do_access(1'b0, 0, $urandom, $urandom);
      idle_cycle(1'b1, 1'b1);
      idle_cycle(1'b0, 1'b1);
      idle_cycle(1'b1, 1'b0);

      repeat (300) begin
         if ($urandom_range(0, 2) == 0)
            idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else
            do_access(1'($urandom_range(0, 1)), int'($urandom_range(0, TO)), $urandom, $urandom);
      end

      do_timeout($urandom);
      async_reset_check("err_reset");
      do_access(1'b1, 1, $urandom, $urandom);
      idle_cycle(1'b0, 1'b0);

      // Park a load in WAIT, then pull reset between clock edges
      @(posedge clk); #1;
      set_in(1'b1, 1'b0, 32'h0000_0040, $urandom, 1'b0, 1'b0, 1'b0);
      expect_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      set_in(1'b1, 1'b0, 32'h0000_0040, $urandom, 1'b0, 1'b0, 1'b0);
      expect_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      async_reset_check("wait_reset");
      do_access(1'b0, 2, $urandom, $urandom);
      idle_cycle(1'b0, 1'b0);

      @(negedge clk); #1;
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
